// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NCH-channel edge-to-pulse generator with sticky per-channel miss flags
// Define PULSE_RETRIG_EN to extend an active pulse on a new edge instead of dropping it and setting MISSED.
module pulse_gen_multi #(
  parameter int NCH   = 4,
  parameter int LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCH-1:0]   LVL_SIG,
  input  logic [1:0]       MODE,
  input  logic [LEN_W-1:0] PULSE_LEN,
  input  logic [NCH-1:0]   MISS_CLR,
  output logic [NCH-1:0]   PULSE_SIG,
  output logic [NCH-1:0]   BUSY,
  output logic [NCH-1:0]   MISSED
);
  typedef enum logic {IDLE, PULSE} state_t;
  logic [NCH-1:0]   lvl_q, rise, fall, edg;
  logic [LEN_W-1:0] len_m1;
  always_ff @(posedge CLK)
    if (RST) lvl_q <= '0;
    else lvl_q <= LVL_SIG;
  always_comb begin
    rise   = LVL_SIG & ~lvl_q;
    fall   = ~LVL_SIG & lvl_q;
    edg    = MODE == 2'b00 ? rise : MODE == 2'b01 ? fall : MODE == 2'b10 ? (rise | fall) : '0;
    len_m1 = PULSE_LEN == '0 ? '0 : PULSE_LEN - LEN_W'(1);
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           st;
    logic [LEN_W-1:0] cnt;
    always_ff @(posedge CLK)
      if (RST) begin
        st  <= IDLE;
        cnt <= '0;
      end else if (st == IDLE) begin
        if (edg[i]) begin
          st  <= PULSE;
          cnt <= len_m1;
        end
`ifdef PULSE_RETRIG_EN
      end else if (edg[i]) begin
        cnt <= len_m1;
`endif
      end else if (cnt == '0) begin
        st <= IDLE;
      end else begin
        cnt <= cnt - LEN_W'(1);
      end
    assign PULSE_SIG[i] = st == PULSE;
    assign BUSY[i]      = st == PULSE;
`ifdef PULSE_RETRIG_EN
    assign MISSED[i] = 1'b0;
`else
    logic missed;
    // a miss in the same cycle as MISS_CLR keeps the flag set
    always_ff @(posedge CLK)
      if (RST) missed <= 1'b0;
      else missed <= (st == PULSE && edg[i]) || (missed && !MISS_CLR[i]);
    assign MISSED[i] = missed;
`endif
  end
endmodule
